grid_sprite_compositor: RTL and testbench

Parametrised successor to the fixed two-player/one-car grid renderer. Converts the VGA driver's pixel coordinates into grid cells and composites NUM_PLAYERS players and NUM_CARS self-moving cars over a background, using a 2-stage pixel pipeline. Also detects player/car overlap as sticky collision flags. Sits between the vga_driver (coordinates, active_pixels) and the VGA DAC pins (VGA_R/G/B), and reports collisions to game logic.

---
 rtl/grid_sprite_compositor.sv | 154 +++++++++++++++
 tb/tb_grid_sprite_compositor.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_sprite_compositor.sv
// Grid renderer: maps VGA pixel coordinates to grid cells and composites players and
// self-moving cars over a background through a 2-stage pipeline. Also keeps sticky
// per-player collision flags.
module grid_sprite_compositor #(
  parameter int unsigned CELL_PX     = 40,
  parameter int unsigned GRID_W      = 16,
  parameter int unsigned GRID_H      = 12,
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned NUM_CARS    = 4,
  parameter int unsigned MOVE_FRAMES = 30,
  parameter logic [23:0] BG_COLOR    = 24'hAACCFF,
  parameter logic [23:0] BLANK_COLOR = 24'hFFFFFF,
  parameter logic [24*NUM_PLAYERS-1:0] PLAYER_COLORS = {24'hC0C0C0, 24'h00FF00},
  parameter logic [23:0] CAR_COLOR   = 24'h800080
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_en,
  input  logic                     active_pixels,
  input  logic [9:0]               x_pixel,
  input  logic [9:0]               y_pixel,
  input  logic                     frame_start,
  input  logic                     pause,
  input  logic [4*NUM_PLAYERS-1:0] player_x,
  input  logic [4*NUM_PLAYERS-1:0] player_y,
  input  logic [4*NUM_CARS-1:0]    car_row,
  input  logic [NUM_CARS-1:0]      car_dir,
  input  logic                     collision_clr,
  output logic [23:0]              vga_rgb,
  output logic                     rgb_active,
  output logic [4*NUM_CARS-1:0]    car_x,
  output logic [NUM_PLAYERS-1:0]   collision
);

  localparam logic [9:0]     CELL    = 10'(CELL_PX);
  localparam int unsigned    FCW     = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;
  localparam logic [FCW-1:0] LAST    = FCW'(MOVE_FRAMES - 1);
  localparam logic [3:0]     COL_MAX = 4'(GRID_W - 1);

  logic [9:0]     w_gx_full, w_gy_full;
  logic [3:0]     r_gx, r_gy;
  logic           r_act1, r_oog1;
  logic [23:0]    w_color;
  logic [23:0]    r_rgb;
  logic           r_rgb_act;
  logic [FCW-1:0] r_cnt;
  logic [3:0]     r_car_x [NUM_CARS];
  logic [3:0]     w_car_next [NUM_CARS];
  logic [NUM_PLAYERS-1:0] w_hit, r_coll;

  assign w_gx_full = x_pixel / CELL;
  assign w_gy_full = y_pixel / CELL;

  // Comparing the full quotient against the grid size is the same test as
  // x >= GRID_W*CELL_PX, and keeps the truncated 4-bit cell index safe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gx   <= '0;
      r_gy   <= '0;
      r_act1 <= 1'b0;
      r_oog1 <= 1'b0;
    end else if (pix_en) begin
      r_gx   <= w_gx_full[3:0];
      r_gy   <= w_gy_full[3:0];
      r_act1 <= active_pixels;
      r_oog1 <= (w_gx_full >= 10'(GRID_W)) || (w_gy_full >= 10'(GRID_H));
    end
  end

  // Lowest-priority sources are written first so player 0 ends up on top.
  always_comb begin
    w_color = BG_COLOR;
    if (!r_act1) begin
      w_color = BLANK_COLOR;
    end else if (!r_oog1) begin
      for (int unsigned c = 0; c < NUM_CARS; c++) begin
        if (r_car_x[c] == r_gx && car_row[4*c +: 4] == r_gy)
          w_color = CAR_COLOR;
      end
      for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
        if (player_x[4*(NUM_PLAYERS-1-k) +: 4] == r_gx &&
            player_y[4*(NUM_PLAYERS-1-k) +: 4] == r_gy)
          w_color = PLAYER_COLORS[24*(NUM_PLAYERS-1-k) +: 24];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb     <= BG_COLOR;
      r_rgb_act <= 1'b0;
    end else if (pix_en) begin
      r_rgb     <= w_color;
      r_rgb_act <= r_act1;
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NUM_CARS; c++) begin
      w_car_next[c] = r_car_x[c];
      if (car_dir[c])
        w_car_next[c] = (r_car_x[c] == '0) ? COL_MAX : r_car_x[c] - 4'd1;
      else
        w_car_next[c] = (r_car_x[c] == COL_MAX) ? '0 : r_car_x[c] + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      for (int unsigned c = 0; c < NUM_CARS; c++)
        r_car_x[c] <= 4'((c * GRID_W) / NUM_CARS);
    end else if (frame_start && !pause) begin
      if (r_cnt == LAST) begin
        r_cnt <= '0;
        for (int unsigned c = 0; c < NUM_CARS; c++)
          r_car_x[c] <= w_car_next[c];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_hit = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      for (int unsigned c = 0; c < NUM_CARS; c++) begin
        if (r_car_x[c] == player_x[4*p +: 4] && car_row[4*c +: 4] == player_y[4*p +: 4])
          w_hit[p] = 1'b1;
      end
    end
  end

  // A hit in the same cycle as a clear keeps its flag set.
  always_ff @(posedge clk) begin
    if (rst)
      r_coll <= '0;
    else if (collision_clr)
      r_coll <= w_hit;
    else
      r_coll <= r_coll | w_hit;
  end

  always_comb begin
    car_x = '0;
    for (int unsigned c = 0; c < NUM_CARS; c++)
      car_x[4*c +: 4] = r_car_x[c];
  end

  assign vga_rgb    = r_rgb;
  assign rgb_active = r_rgb_act;
  assign collision  = r_coll;

endmodule

// File: tb/tb_grid_sprite_compositor.sv
// Self-checking bench for grid_sprite_compositor: directed vector table, hand-written
// pipeline/collision/reset sequences, and randomized traffic against a reference model.
module tb_grid_sprite_compositor;

  logic        clk = 1'b0;
  logic        rst, pix_en, active_pixels, frame_start, pause, collision_clr;
  logic [9:0]  x_pixel, y_pixel;
  logic [7:0]  player_x, player_y;
  logic [15:0] car_row;
  logic [3:0]  car_dir;
  logic [23:0] vga_rgb;
  logic        rgb_active;
  logic [15:0] car_x;
  logic [1:0]  collision;

  int n_vec = 0;
  int n_fail = 0;

  // Reference model state: accepted frame pulses and car steps since reset.
  int         steps = 0;
  int         acc = 0;
  logic [1:0] m_coll = '0;

  always #5 clk = ~clk;

  grid_sprite_compositor #(.MOVE_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .active_pixels(active_pixels),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .frame_start(frame_start), .pause(pause),
    .player_x(player_x), .player_y(player_y), .car_row(car_row), .car_dir(car_dir),
    .collision_clr(collision_clr), .vga_rgb(vga_rgb), .rgb_active(rgb_active),
    .car_x(car_x), .collision(collision)
  );

  function automatic int car_pos(int i);
    int d;
    d = car_dir[i] ? -steps : steps;
    return ((((i * 16) / 4) + d) % 16 + 16) % 16;
  endfunction

  function automatic logic [15:0] cars_packed();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(car_pos(i));
    return r;
  endfunction

  function automatic logic [23:0] ref_color(int x, int y, bit a);
    int gx, gy;
    if (!a) return 24'hFFFFFF;
    if (x >= 640 || y >= 480) return 24'hAACCFF;
    gx = x / 40;
    gy = y / 40;
    if (int'(player_x[3:0]) == gx && int'(player_y[3:0]) == gy) return 24'h00FF00;
    if (int'(player_x[7:4]) == gx && int'(player_y[7:4]) == gy) return 24'hC0C0C0;
    for (int c = 0; c < 4; c++)
      if (car_pos(c) == gx && int'(car_row[4*c +: 4]) == gy) return 24'h800080;
    return 24'hAACCFF;
  endfunction

  task automatic step();
    logic [1:0] hit;
    if (rst) begin
      steps = 0;
      acc = 0;
      m_coll = '0;
    end else begin
      hit = '0;
      for (int p = 0; p < 2; p++)
        for (int c = 0; c < 4; c++)
          if (car_pos(c) == int'(player_x[4*p +: 4]) && car_row[4*c +: 4] == player_y[4*p +: 4])
            hit[p] = 1'b1;
      m_coll = collision_clr ? hit : (m_coll | hit);
      if (frame_start && !pause) begin
        acc++;
        if (acc == 2) begin
          acc = 0;
          steps++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
  endtask

  typedef struct {
    int          x;
    int          y;
    bit          a;
    logic [7:0]  px;
    logic [7:0]  py;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [3:0]  c0;
    logic [23:0] e_rgb;
    logic        e_act;
    int          pr_x, pr_y, n_str, rx, ry;
    bit          pr_a, ra;

    // Cars after one step: car0 (15,1), car1 (5,4), car2 (9,6), car3 (11,9).
    tbl[0]  = '{130, 90, 1'b1, 8'h33, 8'h22, 24'h00FF00};
    tbl[1]  = '{130, 90, 1'b0, 8'h33, 8'h22, 24'hFFFFFF};
    tbl[2]  = '{130, 90, 1'b1, 8'h3F, 8'h2F, 24'hC0C0C0};
    tbl[3]  = '{650, 90, 1'b1, 8'hFF, 8'hFF, 24'hAACCFF};
    tbl[4]  = '{205, 165, 1'b1, 8'hFF, 8'hFF, 24'h800080};
    tbl[5]  = '{639, 479, 1'b1, 8'hFF, 8'hFF, 24'hAACCFF};
    tbl[6]  = '{600, 40, 1'b1, 8'hFF, 8'hFF, 24'h800080};
    tbl[7]  = '{205, 165, 1'b1, 8'h5F, 8'h4F, 24'hC0C0C0};
    tbl[8]  = '{0, 480, 1'b1, 8'hFF, 8'hFF, 24'hAACCFF};
    tbl[9]  = '{1023, 1023, 1'b1, 8'hFF, 8'hFF, 24'hAACCFF};
    tbl[10] = '{1023, 1023, 1'b0, 8'hFF, 8'hFF, 24'hFFFFFF};
    tbl[11] = '{600, 40, 1'b1, 8'hFF, 8'hF1, 24'h00FF00};

    rst = 1'b1; pix_en = 1'b0; active_pixels = 1'b0; x_pixel = '0; y_pixel = '0;
    frame_start = 1'b0; pause = 1'b0; collision_clr = 1'b0;
    player_x = 8'hFF; player_y = 8'hFF;
    car_row = {4'd9, 4'd6, 4'd4, 4'd1};
    car_dir = 4'b1001;
    step();
    step();
    rst = 1'b0;

    chk("reset_car_x", 32'(car_x), 32'(cars_packed()));
    chk("reset_rgb", 32'(vga_rgb), 32'hAACCFF);
    chk("reset_active", 32'(rgb_active), 32'h0);
    chk("reset_collision", 32'(collision), 32'h0);

    pulse();
    pulse();
    chk("step1_car_x", 32'(car_x), 32'(cars_packed()));
    c0 = car_x[3:0];
    chk("step1_car0_wrap", 32'(c0), 32'd15);

    pix_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      x_pixel = 10'(tbl[i].x);
      y_pixel = 10'(tbl[i].y);
      active_pixels = tbl[i].a;
      player_x = tbl[i].px;
      player_y = tbl[i].py;
      step();
      step();
      chk($sformatf("table_rgb_%0d", i), 32'(vga_rgb), 32'(tbl[i].rgb));
      chk($sformatf("table_act_%0d", i), 32'(rgb_active), 32'(tbl[i].a));
    end

    // Two-strobe latency: old colour survives the first strobe after a change.
    player_x = 8'hFF; player_y = 8'hFF; active_pixels = 1'b1;
    x_pixel = 10'd205; y_pixel = 10'd165;
    step();
    step();
    x_pixel = 10'd130; y_pixel = 10'd90;
    step();
    chk("latency_1", 32'(vga_rgb), 32'h800080);
    step();
    chk("latency_2", 32'(vga_rgb), 32'hAACCFF);

    pix_en = 1'b0; x_pixel = 10'd205; y_pixel = 10'd165;
    step();
    chk("pixen_hold_a", 32'(vga_rgb), 32'hAACCFF);
    pix_en = 1'b1;
    step();
    chk("pixen_strobe_a", 32'(vga_rgb), 32'hAACCFF);
    pix_en = 1'b0;
    step();
    chk("pixen_hold_b", 32'(vga_rgb), 32'hAACCFF);
    pix_en = 1'b1;
    step();
    chk("pixen_strobe_b", 32'(vga_rgb), 32'h800080);
    pix_en = 1'b0; x_pixel = 10'd130; y_pixel = 10'd90;
    step();
    chk("pixen_hold_c", 32'(vga_rgb), 32'h800080);
    pix_en = 1'b1;

    collision_clr = 1'b1;
    step();
    collision_clr = 1'b0;
    chk("coll_cleared", 32'(collision), 32'h0);
    player_x = 8'h9F; player_y = 8'h6F;
    step();
    chk("coll_set_p1", 32'(collision), 32'h2);
    player_x = 8'hFF; player_y = 8'hFF;
    step();
    chk("coll_sticky", 32'(collision), 32'h2);
    player_x = 8'h9F; player_y = 8'h6F; collision_clr = 1'b1;
    step();
    chk("coll_set_beats_clr", 32'(collision), 32'h2);
    player_x = 8'hFF; player_y = 8'hFF;
    step();
    chk("coll_clr", 32'(collision), 32'h0);
    collision_clr = 1'b0;
    player_x = 8'hFF; player_y = 8'hF1;
    step();
    chk("coll_set_p0", 32'(collision), 32'h1);
    player_x = 8'hFF; player_y = 8'hFF; collision_clr = 1'b1;
    step();
    collision_clr = 1'b0;
    chk("coll_clr_p0", 32'(collision), 32'h0);

    for (int i = 0; i < 32; i++) pulse();
    chk("step17_car_x", 32'(car_x), 32'(cars_packed()));
    c0 = car_x[3:0];
    chk("step17_car0", 32'(c0), 32'd15);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) pulse();
    chk("pause_hold", 32'(car_x), 32'(cars_packed()));
    pause = 1'b0;
    pulse();
    chk("unpause_first", 32'(car_x), 32'(cars_packed()));
    pulse();
    chk("unpause_second", 32'(car_x), 32'(cars_packed()));

    // Random pixel stream; players change only between blocks.
    pr_x = 0; pr_y = 0; pr_a = 1'b0; e_rgb = '0; e_act = 1'b0;
    for (int blk = 0; blk < 10; blk++) begin
      player_x = 8'($urandom);
      player_y = 8'($urandom);
      n_str = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
        rx = $urandom_range(0, 700);
        ry = $urandom_range(0, 520);
        ra = ($urandom_range(0, 4) != 0);
        pix_en = ($urandom_range(0, 3) != 0);
        x_pixel = 10'(rx); y_pixel = 10'(ry); active_pixels = ra;
        if (pix_en) begin
          e_rgb = ref_color(pr_x, pr_y, pr_a);
          e_act = pr_a;
          pr_x = rx; pr_y = ry; pr_a = ra;
          n_str++;
        end
        step();
        if (n_str >= 2) begin
          chk("rand_rgb", 32'(vga_rgb), 32'(e_rgb));
          chk("rand_act", 32'(rgb_active), 32'(e_act));
        end
      end
    end

    // Random motion, pause and collision traffic.
    pix_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      frame_start   = ($urandom_range(0, 2) == 0);
      pause         = ($urandom_range(0, 3) == 0);
      collision_clr = ($urandom_range(0, 7) == 0);
      for (int p = 0; p < 2; p++) begin
        player_x[4*p +: 4] = 4'($urandom_range(0, 15));
        player_y[4*p +: 4] = car_row[4*$urandom_range(0, 3) +: 4];
      end
      step();
      chk("rand_car_x", 32'(car_x), 32'(cars_packed()));
      chk("rand_collision", 32'(collision), 32'(m_coll));
    end
    frame_start = 1'b0; pause = 1'b0; collision_clr = 1'b0;

    player_x = 8'hFF; player_y = 8'hFF;
    x_pixel = 10'd205; y_pixel = 10'd165; active_pixels = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    chk("midreset_rgb", 32'(vga_rgb), 32'hAACCFF);
    chk("midreset_act", 32'(rgb_active), 32'h0);
    chk("midreset_car_x", 32'(car_x), 32'(cars_packed()));
    chk("midreset_coll", 32'(collision), 32'h0);
    rst = 1'b0;
    player_x = 8'h33; player_y = 8'h22; x_pixel = 10'd130; y_pixel = 10'd90;
    step();
    step();
    chk("postreset_rgb", 32'(vga_rgb), 32'h00FF00);
    chk("postreset_act", 32'(rgb_active), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
